// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD operand sequencer and its helpers:
//   - gcd_state_e : 3-bit state encoding of the sequencer FSM
//   - GCD_WIDTH_DEF / GCD_TIMEOUT_DEF : default parameter values
// No ports (package).
// -----------------------------------------------------------------------------
package gcd_pkg;

  localparam int unsigned GCD_WIDTH_DEF   = 16;
  localparam int unsigned GCD_TIMEOUT_DEF = 2000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRST   = 3'd1,
    ST_LOAD_A = 3'd2,
    ST_LOAD_B = 3'd3,
    ST_HOLD_B = 3'd4,
    ST_WAIT   = 3'd5,
    ST_RESP   = 3'd6
  } gcd_state_e;

endpackage

// File: rtl/gcd_timeout_cnt.sv
// -----------------------------------------------------------------------------
// gcd_timeout_cnt
// Load-clear cycle counter with a terminal flag. Only built when the macro
// GCD_SEQ_TIMEOUT_EN is defined; the default build contains no counter.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset
//   clr   in  synchronous clear (held while the owner is not waiting)
//   en    in  count enable (one increment per enabled cycle)
//   term  out high in the enabled cycle whose increment reaches MAX, so the
//             owner can leave on the same edge the count hits MAX
// -----------------------------------------------------------------------------
`ifdef GCD_SEQ_TIMEOUT_EN
module gcd_timeout_cnt
  import gcd_pkg::*;
#(
  parameter int unsigned MAX = GCD_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int unsigned CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = en && (cnt == CW'(MAX - 1));

endmodule
`endif

// File: rtl/gcd_operand_seq.sv
// -----------------------------------------------------------------------------
// gcd_operand_seq
// Upstream sequencer for the subtractive GCD core. Accepts an operand pair on
// a valid/ready stream, restarts the core, serialises A then B onto the
// shared core data bus with a start pulse, waits for done and returns the
// result on a valid/ready stream. Zero operands bypass the core (the core
// would never terminate on them). One job in flight at a time.
//
// Optional feature: define GCD_SEQ_TIMEOUT_EN to abort a job that sees no
// core_done within TIMEOUT_CYCLES cycles of WAIT (res_err = 1, res_data = 0).
//
// Ports:
//   clk          in   rising-edge clock (shared with the core)
//   rst          in   asynchronous active-low reset
//   in_valid     in   operand pair valid
//   in_ready     out  sequencer can accept a pair (IDLE only)
//   in_a, in_b   in   operands
//   core_rst     out  active-high reset to the core controller
//   core_start   out  one-cycle start pulse to the core
//   core_data    out  core data bus
//   core_done    in   core done
//   core_result  in   core A register output
//   res_valid    out  result valid
//   res_ready    in   result consumer ready
//   res_data     out  GCD result
//   res_err      out  job aborted by timeout
// All outputs are flops loaded from the state being entered.
// -----------------------------------------------------------------------------
module gcd_operand_seq
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = GCD_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_rst,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  gcd_state_e       state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, op_a_nxt, op_b_nxt;
  logic [WIDTH-1:0] core_data_nxt, res_data_nxt;
  logic             in_ready_nxt, core_rst_nxt, core_start_nxt;
  logic             res_valid_nxt, res_err_nxt;
  logic             timeout_hit;
  logic             accept;

`ifdef GCD_SEQ_TIMEOUT_EN
  // Held clear outside WAIT, so it starts from zero on every WAIT entry.
  gcd_timeout_cnt #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != ST_WAIT),
    .en   (state == ST_WAIT),
    .term (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    res_data_nxt = res_data;
    res_err_nxt  = res_err;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_a_nxt = in_a;
          op_b_nxt = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(x,0) = x and gcd(0,0) = 0, both equal to a | b here.
            res_data_nxt = in_a | in_b;
            res_err_nxt  = 1'b0;
            state_nxt    = ST_RESP;
          end else begin
            state_nxt = ST_CRST;
          end
        end
      end
      ST_CRST:   state_nxt = ST_LOAD_A;
      ST_LOAD_A: state_nxt = ST_LOAD_B;
      ST_LOAD_B: state_nxt = ST_HOLD_B;
      ST_HOLD_B: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          res_data_nxt = core_result;
          res_err_nxt  = 1'b0;
          state_nxt    = ST_RESP;
        end else if (timeout_hit) begin
          res_data_nxt = '0;
          res_err_nxt  = 1'b1;
          state_nxt    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    in_ready_nxt   = (state_nxt == ST_IDLE);
    core_start_nxt = (state_nxt == ST_LOAD_A);
    res_valid_nxt  = (state_nxt == ST_RESP);

    case (state_nxt)
      ST_CRST, ST_LOAD_A:          core_data_nxt = op_a_nxt;
      ST_LOAD_B, ST_HOLD_B, ST_WAIT: core_data_nxt = op_b_nxt;
      default:                     core_data_nxt = '0;
    endcase

    // The core stays out of reset through a normal result, goes back into
    // reset on an abort, and is never released for a zero bypass.
    case (state_nxt)
      ST_LOAD_A, ST_LOAD_B, ST_HOLD_B, ST_WAIT: core_rst_nxt = 1'b0;
      ST_RESP: core_rst_nxt = (state == ST_WAIT) ? res_err_nxt : core_rst;
      default: core_rst_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a       <= '0;
      op_b       <= '0;
      in_ready   <= 1'b1;
      core_rst   <= 1'b1;
      core_start <= 1'b0;
      core_data  <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
    end else begin
      op_a       <= op_a_nxt;
      op_b       <= op_b_nxt;
      in_ready   <= in_ready_nxt;
      core_rst   <= core_rst_nxt;
      core_start <= core_start_nxt;
      core_data  <= core_data_nxt;
      res_valid  <= res_valid_nxt;
      res_data   <= res_data_nxt;
      res_err    <= res_err_nxt;
    end
  end

endmodule

// File: tb/tb_gcd_operand_seq.sv
// -----------------------------------------------------------------------------
// tb_gcd_operand_seq
// Self-checking bench for gcd_operand_seq. A small subtractive core model
// answers the sequencer; expected results come from a Euclid (modulo)
// reference function. Directed jobs first, then randomized pairs; the
// timeout job runs only when GCD_SEQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_gcd_operand_seq;

  localparam int W  = 16;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         core_rst;
  logic         core_start;
  logic [W-1:0] core_data;
  logic         core_done;
  logic [W-1:0] core_result;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         res_err;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;

  logic hang = 1'b0;
  logic spur = 1'b0;

  gcd_operand_seq #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .core_rst    (core_rst),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err)
  );

  always #5 clk = ~clk;

  // Core model: loads A on start, B the next cycle, then one subtraction
  // step per cycle until equal; done holds until core_rst.
  logic [W-1:0] ca = '0;
  logic [W-1:0] cb = '0;
  logic [1:0]   cph = '0;
  logic         cdone = 1'b0;

  always @(posedge clk) begin
    if (core_rst) begin
      cph   <= 2'd0;
      cdone <= 1'b0;
    end else begin
      case (cph)
        2'd0: if (core_start) begin ca <= core_data; cph <= 2'd1; end
        2'd1: begin cb <= core_data; cph <= 2'd2; end
        2'd2: begin
          if (ca == cb) begin
            cdone <= !hang;
            cph   <= 2'd3;
          end else if (ca > cb) begin
            ca <= ca - cb;
          end else begin
            cb <= cb - ca;
          end
        end
        default: ;
      endcase
    end
  end

  assign core_done   = cdone | spur;
  assign core_result = ca;

  always @(posedge clk) begin
    if (core_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b, input int rdly,
                        input bit ovl, input logic [W-1:0] na, input logic [W-1:0] nb);
    logic [W-1:0] exp_d;
    logic         exp_e;
    int           s0, dcyc, vcyc;
    bit           leak;
    bit           zero;
    zero  = (a == 0) || (b == 0);
    exp_e = hang && !zero;
    exp_d = exp_e ? '0 : ref_gcd(a, b);

    chk("idle_in_ready", in_ready, 1);
    s0 = start_cnt;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    tick();
    in_valid = 1'b0;
    in_a = W'($urandom);
    in_b = W'($urandom);

    if (zero) begin
      chk("bypass_valid", res_valid, 1);
      chk("bypass_in_ready", in_ready, 0);
    end else begin
      chk("crst_core_rst", core_rst, 1);
      chk("crst_data", core_data, a);
      chk("busy_in_ready", in_ready, 0);
      tick();
      chk("loada_start", core_start, 1);
      chk("loada_core_rst", core_rst, 0);
      chk("loada_data", core_data, a);
      tick();
      chk("loadb_start", core_start, 0);
      chk("loadb_data", core_data, b);
      tick();
      chk("holdb_data", core_data, b);
      chk("holdb_valid", res_valid, 0);
      dcyc = -1;
      vcyc = -1;
      leak = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        tick();
        if (res_valid) begin
          vcyc = i;
          break;
        end
        if (core_done && dcyc < 0) dcyc = i;
        if (in_ready || core_data != b || core_start) leak = 1'b1;
      end
      chk("wait_bounded", vcyc >= 0, 1);
      chk("wait_flags", leak, 0);
      if (exp_e) begin
        chk("timeout_latency", vcyc, TO);
        chk("timeout_core_rst", core_rst, 1);
      end else begin
        chk("done_latency", vcyc - dcyc, 1);
        chk("resp_core_rst", core_rst, 0);
      end
    end

    chk("res_data", res_data, exp_d);
    chk("res_err", res_err, exp_e);
    chk("start_count", start_cnt - s0, zero ? 0 : 1);

    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_d);
      chk("hold_in_ready", in_ready, 0);
    end

    res_ready = 1'b1;
    if (ovl) begin
      in_valid = 1'b1;
      in_a = na;
      in_b = nb;
    end
    tick();
    res_ready = 1'b0;
    chk("hs_valid_drop", res_valid, 0);
    chk("hs_in_ready", in_ready, 1);
    chk("hs_core_rst", core_rst, 1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_data", core_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    do_job(16'd143, 16'd72, 0, 1'b0, '0, '0);
    do_job(16'd48, 16'd18, 0, 1'b1, 16'd8, 16'd8);
    do_job(16'd8, 16'd8, 0, 1'b0, '0, '0);
    do_job(16'd0, 16'd35, 0, 1'b0, '0, '0);
    do_job(16'd0, 16'd0, 0, 1'b0, '0, '0);
    do_job(16'd35, 16'd0, 1, 1'b0, '0, '0);
    do_job(16'd100, 16'd75, 5, 1'b0, '0, '0);

    // A done pulse outside WAIT must not produce a result.
    spur = 1'b1;
    tick();
    tick();
    tick();
    chk("spur_valid", res_valid, 0);
    chk("spur_in_ready", in_ready, 1);
    spur = 1'b0;
    tick();

    // Reset in the middle of WAIT abandons the job.
    in_valid = 1'b1;
    in_a = 16'd143;
    in_b = 16'd72;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_busy", in_ready, 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_core_rst", core_rst, 1);
    chk("mid_rst_core_data", core_data, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    tick();
    tick();
    chk("in_rst_res_valid", res_valid, 0);
    #2 rst = 1'b1;
    tick();
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_core_rst", core_rst, 1);
    do_job(16'd21, 16'd14, 0, 1'b0, '0, '0);

    for (int j = 0; j < 12; j++) begin
      ra = W'($urandom_range(1, 400));
      rb = W'($urandom_range(1, 400));
      if ($urandom_range(0, 5) == 0) ra = '0;
      if ($urandom_range(0, 5) == 0) rb = '0;
      do_job(ra, rb, int'($urandom_range(0, 3)), 1'b0, '0, '0);
    end

`ifdef GCD_SEQ_TIMEOUT_EN
    hang = 1'b1;
    do_job(16'd143, 16'd72, 0, 1'b0, '0, '0);
    hang = 1'b0;
    do_job(16'd48, 16'd18, 0, 1'b0, '0, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
